// File: rtl/pwl_filter_reset_seq.sv
// rtl/pwl_filter_reset_seq.sv - reset sequencer with PWL convergence check for the pwl_filter family
//
// Levels are signed fixed point with FRAC fractional bits. A PWL signal is the
// triple (a, b, t0): value(t) = a + b*(t - t0), with b in level units per cycle.
// Time is the sequencer's own cycle count (time_now), restarted by rstb, and is
// exported so the filter and this block share one timebase.
module pwl_filter_reset_seq #(
  parameter int  CNT_W     = 8,
  parameter int  MAX_RETRY = 2,
  parameter real exp_gain  = 1.0,
  parameter real tol       = 0.01,
  parameter real etol      = 0.005,
  parameter int  LVL_W     = 16,
  parameter int  FRAC      = 12,
  parameter int  TIME_W    = 16,
  parameter int  RW        = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1)
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     start,
  input  logic signed [LVL_W-1:0]  rst_level,
  input  logic [CNT_W-1:0]         hold_cycles,
  input  logic [CNT_W-1:0]         settle_cycles,
  input  logic signed [LVL_W-1:0]  out_a,
  input  logic signed [LVL_W-1:0]  out_b,
  input  logic [TIME_W-1:0]        out_t0,
  output logic                     reset,
  output logic signed [LVL_W-1:0]  in_rst_a,
  output logic signed [LVL_W-1:0]  in_rst_b,
  output logic [TIME_W-1:0]        in_rst_t0,
  output logic                     in_rst_ev,
  output logic [TIME_W-1:0]        time_now,
  output logic [RW-1:0]            retry_cnt,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic signed [LVL_W-1:0]  sample
);

  localparam int PW     = 2 * LVL_W + TIME_W + 2;
  localparam int GAIN_Q = int'(exp_gain * real'(1 << FRAC));
  localparam int TOL_Q  = int'(tol * real'(1 << FRAC));
  localparam int ETOL_Q = int'(etol * real'(1 << FRAC));

  localparam logic signed [PW-1:0]    GAIN_W = PW'(GAIN_Q);
  localparam logic signed [PW-1:0]    TOL_W  = PW'(TOL_Q);
  localparam logic signed [LVL_W:0]   ETOL_W = (LVL_W + 1)'(ETOL_Q);
  localparam logic signed [PW-1:0]    SAT_HI = {{(PW-LVL_W+1){1'b0}}, {(LVL_W-1){1'b1}}};
  localparam logic signed [PW-1:0]    SAT_LO = {{(PW-LVL_W+1){1'b1}}, {(LVL_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, HOLD, CHECK, SETTLE, DONE, ERR} state_t;

  state_t                   state, state_n;
  logic [CNT_W-1:0]         hold_cnt, hold_ld, settle_cnt, hold_eff;
  logic signed [LVL_W-1:0]  lvl_q, eval_s;
  logic [TIME_W-1:0]        dt_u;
  logic signed [PW-1:0]     dt_w, a_w, b_w, eval_w, target_w, diff_w, abs_w;
  logic signed [LVL_W:0]    dl, dl_abs;
  logic                     accept, pass, retry_ok, lvl_far;

  // in_rst is always a constant level
  assign in_rst_b = '0;

  // Evaluate the fed-back PWL output at the current edge and judge convergence
  always_comb begin
    dt_u   = time_now - out_t0;
    dt_w   = {{(PW-TIME_W){dt_u[TIME_W-1]}}, dt_u};
    a_w    = {{(PW-LVL_W){out_a[LVL_W-1]}}, out_a};
    b_w    = {{(PW-LVL_W){out_b[LVL_W-1]}}, out_b};
    eval_w = a_w + b_w * dt_w;
    if (eval_w > SAT_HI) begin
      eval_s = {1'b0, {(LVL_W-1){1'b1}}};
    end else if (eval_w < SAT_LO) begin
      eval_s = {1'b1, {(LVL_W-1){1'b0}}};
    end else begin
      eval_s = eval_w[LVL_W-1:0];
    end
    target_w = (GAIN_W * {{(PW-LVL_W){lvl_q[LVL_W-1]}}, lvl_q}) >>> FRAC;
    diff_w   = {{(PW-LVL_W){eval_s[LVL_W-1]}}, eval_s} - target_w;
    abs_w    = diff_w[PW-1] ? -diff_w : diff_w;
    pass     = (abs_w <= TOL_W);
    retry_ok = (int'(retry_cnt) < MAX_RETRY);
    // Only a level change beyond etol is worth a new PWL event
    dl       = {rst_level[LVL_W-1], rst_level} - {in_rst_a[LVL_W-1], in_rst_a};
    dl_abs   = dl[LVL_W] ? -dl : dl;
    lvl_far  = (dl_abs > ETOL_W);
    hold_eff = (hold_cycles == '0) ? CNT_W'(1) : hold_cycles;
  end

  // State register
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state and decoded outputs; err is sticky simply because ERR is held
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    reset   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = HOLD;
        end
      end
      HOLD: begin
        reset = 1'b1;
        busy  = 1'b1;
        if (hold_cnt <= CNT_W'(1)) state_n = CHECK;
      end
      CHECK: begin
        reset = 1'b1;
        busy  = 1'b1;
        if (pass)          state_n = SETTLE;
        else if (retry_ok) state_n = HOLD;
        else               state_n = ERR;
      end
      SETTLE: begin
        busy = 1'b1;
        if (settle_cnt <= CNT_W'(1)) state_n = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept  = 1'b1;
          state_n = HOLD;
        end else begin
          state_n = IDLE;
        end
      end
      ERR: begin
        err = 1'b1;
        if (start) begin
          accept  = 1'b1;
          state_n = HOLD;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath: timebase, latched level, counters, sample and the in_rst PWL
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      time_now   <= '0;
      lvl_q      <= '0;
      hold_ld    <= '0;
      hold_cnt   <= '0;
      settle_cnt <= '0;
      retry_cnt  <= '0;
      sample     <= '0;
      in_rst_a   <= '0;
      in_rst_t0  <= '0;
      in_rst_ev  <= 1'b0;
    end else begin
      time_now  <= time_now + 1'b1;
      in_rst_ev <= 1'b0;
      if (accept) begin
        lvl_q     <= rst_level;
        hold_ld   <= hold_eff;
        hold_cnt  <= hold_eff;
        retry_cnt <= '0;
        if (lvl_far) begin
          in_rst_a  <= rst_level;
          in_rst_t0 <= time_now;
          in_rst_ev <= 1'b1;
        end
      end
      case (state)
        HOLD: begin
          if (hold_cnt > CNT_W'(1)) hold_cnt <= hold_cnt - 1'b1;
        end
        CHECK: begin
          sample <= eval_s;
          if (pass) begin
            settle_cnt <= settle_cycles;
          end else if (retry_ok) begin
            retry_cnt <= retry_cnt + 1'b1;
            hold_cnt  <= hold_ld;
          end
        end
        SETTLE: begin
          if (settle_cnt > CNT_W'(1)) settle_cnt <= settle_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
